mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM-side axi_bus_rw port between two cache requesters: icache (read-only) and dcache (read and write).
- Sits between the L1 caches and main memory. Each cache sees a private RAM port; the arbiter serialises line fills and writebacks onto the real RAM port.
- Round-robin grant, one outstanding transaction at a time, grant held until that transaction completes.

Parameters:
- ADDR_W, 32, byte-address width of all ports.
- LINE_W, 128, cache-line data width (read_data, write_data).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  single clock; everything is sampled on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- icache  axi_bus_rw.device  bus  requester 0. Only the read channel is used; write_addr_valid is ignored and write_addr_ready is tied 0.
- dcache  axi_bus_rw.device  bus  requester 1. Read and write channels.
- ram  axi_bus_rw.controller  bus  shared memory port.

Behaviour:
- Reset values, applied asynchronously on RESET_N=0:
  - All ready/valid outputs on all ports = 0.
  - ram addresses, data and strobe = 0.
  - state = ARB_IDLE, last_grant = REQ_D, so icache wins the first tie.
- States:
  - ARB_IDLE: no transaction in flight.
  - ARB_READ: forwarding the granted requester's read.
  - ARB_WRITE: forwarding dcache's write.
- ARB_IDLE, request sampling:
  - icache request = icache.read_addr_valid.
  - dcache request = dcache.read_addr_valid | dcache.write_addr_valid. If dcache has both set, its read is served first.
  - One requester: grant it. Both: grant the one != last_grant.
  - On grant, register the requester id, address, write_data and strobe. Set last_grant. Go to ARB_READ or ARB_WRITE next cycle.
  - No output is asserted in the grant cycle, so a grant adds 1 cycle of latency.
- ARB_READ:
  - ram.read_addr = registered address; ram.read_addr_valid = 1.
  - ram.read_data and ram.read_data_valid are forwarded combinationally to the granted requester only. The other requester sees read_data_valid = 0 and read_addr_ready = 0.
  - When ram.read_data_valid = 1, the transaction is complete. Drop ram.read_addr_valid the same cycle and return to ARB_IDLE.
- ARB_WRITE:
  - ram.write_addr, write_data and strobe come from the registers; ram.write_addr_valid = 1.
  - dcache.write_addr_ready and dcache.write_resp_valid mirror ram.write_addr_ready.
  - The transaction completes on the cycle ram.write_addr_valid & ram.write_addr_ready; return to ARB_IDLE.
- Requester ready signals:
  - Are 0 for any requester that is not granted and in flight.
  - The requester must hold its valid and address until its completion cycle. A request dropped mid-transaction does not abort the RAM transaction; the result is discarded.
- Back-to-back: from ARB_IDLE a new grant can occur in the cycle after completion, giving minimum 1 idle cycle between RAM transactions.
- Fairness: with both requesters continuously requesting, grants alternate I, D, I, D.
- Reset mid-transaction: the ram valids drop immediately (async). Recovering the RAM is the memory model's responsibility.
- Address and data widths pass through unchanged; there is no width conversion.

Optional Feature:
- Macro: MEM_ARBITER_PERF_CNT_EN.
- Defined: adds outputs perf_grants_i, perf_grants_d and perf_wait_cycles (each CNT_W bits, reset 0).
  - grants_i and grants_d increment by 1 on each grant to that requester.
  - wait_cycles increments on each cycle in which a requester has a request pending but is not granted and in flight.
  - All counters saturate at all-ones; they do not wrap.
- Undefined: these ports and all counter logic are absent. Functional behaviour is identical.

Decomposition:
- Package arb_def holds:
  - typedef enum arb_state_type {ARB_IDLE, ARB_READ, ARB_WRITE};
  - typedef enum logic {REQ_I, REQ_D} req_id_type;
  - a packed struct arb_req_type {addr, data, strobe, is_write}.
- One sub-module, rr_pick2: combinational two-way round-robin picker (inputs req[1:0], last; outputs gnt_valid, gnt_id).

Test Plan:
- Reset then icache read of 0x0000_1230 alone -> ram.read_addr = 0x0000_1230 one cycle after request. A RAM response of 0xDEAD..BEEF after 3 cycles reaches icache.read_data with read_data_valid = 1; dcache sees nothing.
- icache and dcache both request reads in the same cycle after reset -> icache granted first. dcache's read (0x0000_2000) issues on the cycle after icache completion + 1; grant order I, D.
- Both requesters hold requests for 6 transactions -> grant sequence I, D, I, D, I, D with no starvation.
- dcache write 0x0000_3010, strobe 0xF, while RAM holds write_addr_ready = 0 for 4 cycles -> ram.write_addr_valid stays 1 with stable address and data. Completion and dcache.write_resp_valid occur on the ready cycle; icache is blocked throughout.
- dcache asserts read and write in the same cycle -> read served first, then the write. RESET_N pulled low during ARB_READ -> all valids drop asynchronously and state = ARB_IDLE.
- With MEM_ARBITER_PERF_CNT_EN defined, run the 6-transaction alternation -> perf_grants_i = 3, perf_grants_d = 3, perf_wait_cycles matches the cycles counted by the bench.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_def : shared types for mem_arbiter
//
// Purpose : state and requester-id enums plus the registered request record
//           used by the two-way RAM arbiter and its round-robin picker.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package arb_def;

  // Default widths of the arbiter datapath. mem_arbiter's ADDR_W/LINE_W
  // default to these, and the request record below is sized by them.
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 128;
  localparam int ARB_STRB_W = ARB_LINE_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_WRITE
  } arb_state_type;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_type;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_LINE_W-1:0] data;
    logic [ARB_STRB_W-1:0] strobe;
    logic                  is_write;
  } arb_req_type;

endpackage

// File: rtl/axi_bus_rw.sv
// -----------------------------------------------------------------------------
// axi_bus_rw : simplified line-wide read/write memory bus
//
// Purpose : one read channel (addr/valid/ready, data/valid) and one write
//           channel (addr/data/strobe/valid/ready, response valid).
// Modports: controller - issues requests (drives addresses, valids, data)
//           device     - serves requests (drives readies, read data, resp)
// -----------------------------------------------------------------------------
interface axi_bus_rw #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  localparam int STRB_W = LINE_W / 8;

  logic [ADDR_W-1:0] read_addr;
  logic              read_addr_valid;
  logic              read_addr_ready;
  logic [LINE_W-1:0] read_data;
  logic              read_data_valid;
  logic [ADDR_W-1:0] write_addr;
  logic              write_addr_valid;
  logic              write_addr_ready;
  logic [LINE_W-1:0] write_data;
  logic [STRB_W-1:0] write_strobe;
  logic              write_resp_valid;

  modport controller (
    output read_addr, read_addr_valid,
    input  read_addr_ready, read_data, read_data_valid,
    output write_addr, write_addr_valid, write_data, write_strobe,
    input  write_addr_ready, write_resp_valid
  );

  modport device (
    input  read_addr, read_addr_valid,
    output read_addr_ready, read_data, read_data_valid,
    input  write_addr, write_addr_valid, write_data, write_strobe,
    output write_addr_ready, write_resp_valid
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2 : combinational two-way round-robin picker
//
// Purpose : choose between requester 0 (REQ_I) and requester 1 (REQ_D).
//           A lone requester always wins; on a tie the one that was not
//           granted last time wins.
// Ports   : req[1:0]  in  request vector, bit 0 = icache, bit 1 = dcache
//           last      in  id of the previous grant
//           gnt_valid out at least one request present
//           gnt_id    out id of the winner (meaningful when gnt_valid)
// -----------------------------------------------------------------------------
module rr_pick2
  import arb_def::*;
(
  input  logic [1:0] req,
  input  req_id_type last,
  output logic       gnt_valid,
  output req_id_type gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_I;
    if (req == 2'b11) begin
      gnt_id = (last == REQ_I) ? REQ_D : REQ_I;
    end else if (req[1]) begin
      gnt_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter : shares one RAM port between icache and dcache
//
// Purpose : round-robin arbitration, one outstanding RAM transaction at a
//           time, grant held until that transaction completes. A grant
//           costs one idle cycle before the RAM request appears.
// Ports   : clk      in   clock, posedge
//           RESET_N  in   asynchronous active-low reset
//           icache   axi_bus_rw.device      requester 0, read channel only
//           dcache   axi_bus_rw.device      requester 1, read and write
//           ram      axi_bus_rw.controller  shared memory port
//           perf_grants_i/perf_grants_d/perf_wait_cycles  out [CNT_W]
//                    saturating counters, present only when the macro
//                    MEM_ARBITER_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module mem_arbiter
  import arb_def::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
`ifdef MEM_ARBITER_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic             clk,
  input  logic             RESET_N,
  axi_bus_rw.device        icache,
  axi_bus_rw.device        dcache,
  axi_bus_rw.controller    ram
`ifdef MEM_ARBITER_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_grants_i,
  output logic [CNT_W-1:0] perf_grants_d,
  output logic [CNT_W-1:0] perf_wait_cycles
`endif
);

  arb_state_type     r_state;
  arb_state_type     w_state_nxt;
  req_id_type        r_last;
  req_id_type        w_last_nxt;
  req_id_type        r_id;
  req_id_type        w_id_nxt;
  arb_req_type       r_req;
  arb_req_type       w_req_nxt;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_gnt_valid;
  req_id_type        w_gnt_id;
  logic              w_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] w_sel_data;
  logic              w_rd_i;
  logic              w_rd_d;
  logic              w_wr;
  logic              w_unused_ok;

  // icache's write channel is never used; is_write only documents the record.
  assign w_unused_ok = ^{icache.write_addr, icache.write_addr_valid,
                         icache.write_data, icache.write_strobe, r_req.is_write};

  assign w_req_i = icache.read_addr_valid;
  assign w_req_d = dcache.read_addr_valid | dcache.write_addr_valid;

  rr_pick2 u_pick (
    .req       ({w_req_d, w_req_i}),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // dcache read takes precedence over its own write when both are raised.
  always_comb begin
    w_sel_addr = icache.read_addr;
    if (w_gnt_id == REQ_D) begin
      w_sel_addr = dcache.read_addr_valid ? dcache.read_addr : dcache.write_addr;
    end
  end

  assign w_sel_data = dcache.write_data;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_id_nxt    = r_id;
    w_req_nxt   = r_req;
    w_grant     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_valid) begin
          w_grant          = 1'b1;
          w_id_nxt         = w_gnt_id;
          w_last_nxt       = w_gnt_id;
          w_req_nxt.addr   = w_sel_addr;
          w_req_nxt.data   = w_sel_data;
          w_req_nxt.strobe = dcache.write_strobe;
          if ((w_gnt_id == REQ_D) && !dcache.read_addr_valid) begin
            w_req_nxt.is_write = 1'b1;
            w_state_nxt        = ARB_WRITE;
          end else begin
            w_req_nxt.is_write = 1'b0;
            w_state_nxt        = ARB_READ;
          end
        end
      end
      ARB_READ: begin
        if (ram.read_data_valid) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_WRITE: begin
        if (ram.write_addr_ready) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ARB_IDLE;
      r_last  <= REQ_D;
      r_id    <= REQ_I;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_id    <= w_id_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // Everything below is decoded from registered state, so the async reset
  // drops every valid/ready immediately.
  assign w_rd_i = (r_state == ARB_READ) && (r_id == REQ_I);
  assign w_rd_d = (r_state == ARB_READ) && (r_id == REQ_D);
  assign w_wr   = (r_state == ARB_WRITE);

  assign ram.read_addr        = r_req.addr;
  assign ram.read_addr_valid  = (r_state == ARB_READ);
  assign ram.write_addr       = r_req.addr;
  assign ram.write_addr_valid = w_wr;
  assign ram.write_data       = r_req.data;
  assign ram.write_strobe     = r_req.strobe;

  assign icache.read_addr_ready  = w_rd_i & ram.read_addr_ready;
  assign icache.read_data        = w_rd_i ? ram.read_data : '0;
  assign icache.read_data_valid  = w_rd_i & ram.read_data_valid;
  assign icache.write_addr_ready = 1'b0;
  assign icache.write_resp_valid = 1'b0;

  assign dcache.read_addr_ready  = w_rd_d & ram.read_addr_ready;
  assign dcache.read_data        = w_rd_d ? ram.read_data : '0;
  assign dcache.read_data_valid  = w_rd_d & ram.read_data_valid;
  assign dcache.write_addr_ready = w_wr & ram.write_addr_ready;
  assign dcache.write_resp_valid = w_wr & ram.write_addr_ready;

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic w_fly_i;
  logic w_fly_d;
  logic w_wait;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_fly_i = (r_state != ARB_IDLE) && (r_id == REQ_I);
  assign w_fly_d = (r_state != ARB_IDLE) && (r_id == REQ_D);
  // One increment per cycle when either requester is left waiting,
  // including the grant cycle itself (nothing is in flight yet).
  assign w_wait  = (w_req_i & ~w_fly_i) | (w_req_d & ~w_fly_d);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_grants_i    <= '0;
      perf_grants_d    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (w_grant && (w_gnt_id == REQ_I)) perf_grants_i <= sat_inc(perf_grants_i);
      if (w_grant && (w_gnt_id == REQ_D)) perf_grants_d <= sat_inc(perf_grants_d);
      if (w_wait) perf_wait_cycles <= sat_inc(perf_wait_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam logic [127:0] DB = 128'hDEAD0000_11112222_33334444_0000BEEF;
  localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] WD = 128'hCAFEF00D_A5A5A5A5_5A5A5A5A_12345678;
  localparam logic [15:0]  WS = 16'h000F;
  localparam logic [31:0]  A  = 32'h0000_1230;
  localparam logic [31:0]  B  = 32'h0000_2000;
  localparam logic [31:0]  C  = 32'h0000_1500;
  localparam logic [31:0]  W  = 32'h0000_3010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axi_bus_rw #(.ADDR_W(32), .LINE_W(128)) icache_if ();
  axi_bus_rw #(.ADDR_W(32), .LINE_W(128)) dcache_if ();
  axi_bus_rw #(.ADDR_W(32), .LINE_W(128)) ram_if ();

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [31:0] perf_gi, perf_gd, perf_wc;
  int exp_wait = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_wait <= 0;
    else if (icache_if.read_addr_valid &&
             (dcache_if.read_addr_valid || dcache_if.write_addr_valid))
      exp_wait <= exp_wait + 1;
  end
`endif

  mem_arbiter dut (
    .clk     (clk),
    .RESET_N (rst_n),
    .icache  (icache_if),
    .dcache  (dcache_if),
    .ram     (ram_if)
`ifdef MEM_ARBITER_PERF_CNT_EN
    ,
    .perf_grants_i    (perf_gi),
    .perf_grants_d    (perf_gd),
    .perf_wait_cycles (perf_wc)
`endif
  );

  typedef struct {
    logic iv; logic [31:0] ia; logic drv; logic [31:0] dra; logic dwv; logic [31:0] dwa;
    logic rdv; logic [127:0] rd; logic war;
    logic e_rav; logic [31:0] e_ra; logic e_wav; logic [31:0] e_wa;
    logic e_ird; logic e_drd; logic e_dwr;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mkv(logic iv, logic [31:0] ia, logic drv, logic [31:0] dra,
                               logic dwv, logic [31:0] dwa, logic rdv, logic [127:0] rd,
                               logic war, logic e_rav, logic [31:0] e_ra, logic e_wav,
                               logic [31:0] e_wa, logic e_ird, logic e_drd, logic e_dwr);
    vec_t v;
    v.iv = iv; v.ia = ia; v.drv = drv; v.dra = dra; v.dwv = dwv; v.dwa = dwa;
    v.rdv = rdv; v.rd = rd; v.war = war;
    v.e_rav = e_rav; v.e_ra = e_ra; v.e_wav = e_wav; v.e_wa = e_wa;
    v.e_ird = e_ird; v.e_drd = e_drd; v.e_dwr = e_dwr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    icache_if.read_addr_valid  = v.iv;
    icache_if.read_addr        = v.ia;
    dcache_if.read_addr_valid  = v.drv;
    dcache_if.read_addr        = v.dra;
    dcache_if.write_addr_valid = v.dwv;
    dcache_if.write_addr       = v.dwa;
    ram_if.read_data_valid     = v.rdv;
    ram_if.read_data           = v.rd;
    ram_if.write_addr_ready    = v.war;
  endtask

  task automatic idle_inputs();
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Reset with RAM responses forced high: nothing may leak to the requesters.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    ram_if.read_data_valid  = 1'b1;
    ram_if.write_addr_ready = 1'b1;
    #1;
    chk({tag, "_ram_rav"}, ram_if.read_addr_valid, 0);
    chk({tag, "_ram_wav"}, ram_if.write_addr_valid, 0);
    chk({tag, "_ram_ra"}, ram_if.read_addr, 0);
    chk({tag, "_ram_wd"}, ram_if.write_data, 0);
    chk({tag, "_ram_ws"}, ram_if.write_strobe, 0);
    chk({tag, "_i_rdv"}, icache_if.read_data_valid, 0);
    chk({tag, "_d_rdv"}, dcache_if.read_data_valid, 0);
    chk({tag, "_d_war"}, dcache_if.write_addr_ready, 0);
    chk({tag, "_d_wrv"}, dcache_if.write_resp_valid, 0);
    step();
    step();
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] exp_addr;

    icache_if.write_addr_valid = 1'b0;
    icache_if.write_addr       = '0;
    icache_if.write_data       = '0;
    icache_if.write_strobe     = '0;
    dcache_if.write_data       = WD;
    dcache_if.write_strobe     = WS;
    ram_if.read_addr_ready     = 1'b1;

    vecs[0]  = mkv(1, A, 1, B, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, A, 1, B, 0, 0, 0, 0,  0, 1, A, 0, 0, 0, 0, 0);
    vecs[2]  = mkv(1, A, 1, B, 0, 0, 1, DB, 0, 1, A, 0, 0, 1, 0, 0);
    vecs[3]  = mkv(0, 0, 1, B, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mkv(0, 0, 1, B, 0, 0, 0, 0,  0, 1, B, 0, 0, 0, 0, 0);
    vecs[5]  = mkv(0, 0, 1, B, 0, 0, 1, D2, 0, 1, B, 0, 0, 0, 1, 0);
    vecs[6]  = mkv(1, A, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(1, A, 0, 0, 0, 0, 0, 0,  0, 1, A, 0, 0, 0, 0, 0);
    vecs[8]  = mkv(1, A, 0, 0, 0, 0, 0, 0,  0, 1, A, 0, 0, 0, 0, 0);
    vecs[9]  = mkv(1, A, 0, 0, 0, 0, 0, 0,  0, 1, A, 0, 0, 0, 0, 0);
    vecs[10] = mkv(1, A, 0, 0, 0, 0, 1, DB, 0, 1, A, 0, 0, 1, 0, 0);
    vecs[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mkv(1, C, 0, 0, 1, W, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 13; k <= 16; k++)
      vecs[k] = mkv(1, C, 0, 0, 1, W, 0, 0, 0, 0, 0, 1, W, 0, 0, 0);
    vecs[17] = mkv(1, C, 0, 0, 1, W, 0, 0,  1, 0, 0, 1, W, 0, 0, 1);
    vecs[18] = mkv(1, C, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[19] = mkv(1, C, 0, 0, 0, 0, 1, DB, 0, 1, C, 0, 0, 1, 0, 0);
    vecs[20] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);

    #2;
    do_reset("rst0");

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_ram_rav", i), ram_if.read_addr_valid, vecs[i].e_rav);
      if (vecs[i].e_rav) chk($sformatf("v%0d_ram_ra", i), ram_if.read_addr, vecs[i].e_ra);
      chk($sformatf("v%0d_ram_wav", i), ram_if.write_addr_valid, vecs[i].e_wav);
      if (vecs[i].e_wav) begin
        chk($sformatf("v%0d_ram_wa", i), ram_if.write_addr, vecs[i].e_wa);
        chk($sformatf("v%0d_ram_wd", i), ram_if.write_data, WD);
        chk($sformatf("v%0d_ram_ws", i), ram_if.write_strobe, WS);
      end
      chk($sformatf("v%0d_i_rdv", i), icache_if.read_data_valid, vecs[i].e_ird);
      if (vecs[i].e_ird) chk($sformatf("v%0d_i_rd", i), icache_if.read_data, vecs[i].rd);
      chk($sformatf("v%0d_d_rdv", i), dcache_if.read_data_valid, vecs[i].e_drd);
      if (vecs[i].e_drd) chk($sformatf("v%0d_d_rd", i), dcache_if.read_data, vecs[i].rd);
      chk($sformatf("v%0d_d_war", i), dcache_if.write_addr_ready, vecs[i].e_dwr);
      chk($sformatf("v%0d_d_wrv", i), dcache_if.write_resp_valid, vecs[i].e_dwr);
      chk($sformatf("v%0d_i_war", i), icache_if.write_addr_ready, 0);
      step();
    end

    // Both requesters hold reads for six transactions: grants alternate I, D.
    do_reset("rst1");
    icache_if.read_addr_valid = 1'b1;
    icache_if.read_addr       = 32'h0000_4000;
    dcache_if.read_addr_valid = 1'b1;
    dcache_if.read_addr       = 32'h0000_5000;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!ram_if.read_addr_valid && n < 10);
      chk($sformatf("rr%0d_issue", t), ram_if.read_addr_valid, 1);
      exp_addr = (t % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000;
      chk($sformatf("rr%0d_addr", t), ram_if.read_addr, exp_addr);
      ram_if.read_data       = D2;
      ram_if.read_data_valid = 1'b1;
      #1;
      chk($sformatf("rr%0d_i_rdv", t), icache_if.read_data_valid, (t % 2 == 0));
      chk($sformatf("rr%0d_d_rdv", t), dcache_if.read_data_valid, (t % 2 == 1));
      step();
      ram_if.read_data_valid = 1'b0;
    end
    icache_if.read_addr_valid = 1'b0;
    dcache_if.read_addr_valid = 1'b0;
    #1;
`ifdef MEM_ARBITER_PERF_CNT_EN
    chk("perf_grants_i", perf_gi, 3);
    chk("perf_grants_d", perf_gd, 3);
    chk("perf_wait_cycles", perf_wc, exp_wait);
`endif

    // dcache read and write together: read first, then the write.
    dcache_if.read_addr_valid  = 1'b1;
    dcache_if.read_addr        = 32'h0000_6000;
    dcache_if.write_addr_valid = 1'b1;
    dcache_if.write_addr       = 32'h0000_6010;
    step();
    chk("rw_rd_rav", ram_if.read_addr_valid, 1);
    chk("rw_rd_ra", ram_if.read_addr, 32'h0000_6000);
    chk("rw_rd_wav", ram_if.write_addr_valid, 0);
    ram_if.read_data       = D2;
    ram_if.read_data_valid = 1'b1;
    #1;
    chk("rw_d_rdv", dcache_if.read_data_valid, 1);
    chk("rw_d_rd", dcache_if.read_data, D2);
    step();
    ram_if.read_data_valid    = 1'b0;
    dcache_if.read_addr_valid = 1'b0;
    #1;
    chk("rw_gap_rav", ram_if.read_addr_valid, 0);
    chk("rw_gap_wav", ram_if.write_addr_valid, 0);
    step();
    chk("rw_wr_wav", ram_if.write_addr_valid, 1);
    chk("rw_wr_wa", ram_if.write_addr, 32'h0000_6010);
    ram_if.write_addr_ready = 1'b1;
    #1;
    chk("rw_d_wrv", dcache_if.write_resp_valid, 1);
    step();
    ram_if.write_addr_ready    = 1'b0;
    dcache_if.write_addr_valid = 1'b0;
    #1;
    chk("rw_done_wav", ram_if.write_addr_valid, 0);

    // Reset asserted while a read is in flight.
    icache_if.read_addr_valid = 1'b1;
    icache_if.read_addr       = 32'h0000_7000;
    step();
    step();
    chk("mid_rav_before", ram_if.read_addr_valid, 1);
    chk("mid_ra_before", ram_if.read_addr, 32'h0000_7000);
    ram_if.read_data       = DB;
    ram_if.read_data_valid = 1'b1;
    #1;
    chk("mid_i_rdv_before", icache_if.read_data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rav_reset", ram_if.read_addr_valid, 0);
    chk("mid_ra_reset", ram_if.read_addr, 0);
    chk("mid_i_rdv_reset", icache_if.read_data_valid, 0);
    step();
    rst_n = 1'b1;
    icache_if.read_addr_valid = 1'b0;
    ram_if.read_data_valid    = 1'b0;
    #1;
    chk("mid_idle_rav", ram_if.read_addr_valid, 0);
    step();
    chk("mid_idle2_rav", ram_if.read_addr_valid, 0);
    chk("mid_idle2_wav", ram_if.write_addr_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
